// File: rtl/midi_message_tx.sv
// rtl/midi_message_tx.sv - MIDI message serialiser (8N1, LSB first) with running-status suppression
//
// Accepts one MIDI message (status + 0..2 data bytes) per valid/ready handshake
// and shifts it out on MIDI_OUT at MIDI_BAUD.
//
// Ports:
//   sys_clk     system clock, rising edge
//   sys_rst_n   asynchronous active-low reset
//   MIDI_CMD    status byte of the message
//   MIDI_DAT_0  first data byte
//   MIDI_DAT_1  second data byte
//   MSG_VALID   message present on MIDI_CMD / MIDI_DAT_*
//   MSG_READY   idle, a message can be accepted
//   MIDI_OUT    serial line, idle high
//   TX_BUSY     message in progress
//   MSG_ERR     one-cycle strobe: accepted status byte was invalid, message dropped

`timescale 1ns/1ps

module midi_message_tx #(
  parameter int BYTE_W    = 8,
  parameter int SYSCLK_F  = 24000000,
  parameter int MIDI_BAUD = 31250,
  parameter int RS_ENABLE = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [BYTE_W-1:0] MIDI_CMD,
  input  logic [BYTE_W-1:0] MIDI_DAT_0,
  input  logic [BYTE_W-1:0] MIDI_DAT_1,
  input  logic              MSG_VALID,
  output logic              MSG_READY,
  output logic              MIDI_OUT,
  output logic              TX_BUSY,
  output logic              MSG_ERR
);

  localparam int BIT_CNT = SYSCLK_F / MIDI_BAUD;
  localparam int TW      = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam int IW      = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(BIT_CNT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BYTE_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_NEXT
  } state_t;

  state_t state_q, state_d;

  logic [BYTE_W-1:0] cmd_q, d0_q, d1_q;
  logic [BYTE_W-1:0] tx_byte_q;   // byte currently on the line
  logic [BYTE_W-1:0] nxt_byte_q;  // byte to load in NEXT
  logic [BYTE_W-1:0] rs_q;        // stored running status, 0 = none
  logic [1:0]        rem_q;       // bytes still to send after tx_byte_q
  logic [TW-1:0]     bit_tmr_q;
  logic [IW-1:0]     bit_idx_q;
  logic              line_q;
  logic              err_q;

  logic       tick;
  logic       is_status, is_chan, is_common, skip_status;
  logic [1:0] n_data;
  logic [3:0] hi_nib, lo_nib;

  assign hi_nib = cmd_q[BYTE_W-1 -: 4];
  assign lo_nib = cmd_q[BYTE_W-5 -: 4];
  assign tick   = (bit_tmr_q == TMR_LAST);

  // Status decode on the latched command: data-byte count and message class
  always_comb begin
    is_status   = cmd_q[BYTE_W-1];
    is_chan     = 1'b0;
    is_common   = 1'b0;
    n_data      = 2'd0;
    if (is_status) begin
      if (hi_nib != 4'hF) begin
        is_chan = 1'b1;
        n_data  = (hi_nib == 4'hC || hi_nib == 4'hD) ? 2'd1 : 2'd2;
      end else begin
        // 0xF0..0xF7 system common, 0xF8..0xFF realtime
        is_common = ~lo_nib[3];
        case (lo_nib)
          4'h1, 4'h3: n_data = 2'd1;
          4'h2:       n_data = 2'd2;
          default:    n_data = 2'd0;
        endcase
      end
    end
    skip_status = (RS_ENABLE != 0) && is_chan && (cmd_q == rs_q);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (MSG_VALID) state_d = ST_LOAD;
      ST_LOAD:  state_d = is_status ? ST_START : ST_IDLE;
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA:  if (tick && bit_idx_q == IDX_LAST) state_d = ST_STOP;
      // The NEXT gap only separates bytes of one message; the last stop
      // bit hands straight back to IDLE.
      ST_STOP:  if (tick) state_d = (rem_q != 2'd0) ? ST_NEXT : ST_IDLE;
      ST_NEXT:  state_d = ST_START;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      tx_byte_q  <= '0;
      nxt_byte_q <= '0;
      rs_q       <= '0;
      rem_q      <= 2'd0;
      bit_tmr_q  <= '0;
      bit_idx_q  <= '0;
      line_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == ST_LOAD) && !is_status;

      // Line is registered from the state, so the start bit appears one
      // cycle after START is entered (two cycles after the accept edge).
      case (state_q)
        ST_START: line_q <= 1'b0;
        ST_DATA:  line_q <= tx_byte_q[bit_idx_q];
        default:  line_q <= 1'b1;
      endcase

      if (state_q == ST_IDLE && MSG_VALID) begin
        cmd_q <= MIDI_CMD;
        d0_q  <= MIDI_DAT_0;
        d1_q  <= MIDI_DAT_1;
      end

      if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP)
        bit_tmr_q <= tick ? '0 : bit_tmr_q + 1'b1;
      else
        bit_tmr_q <= '0;

      if (state_q == ST_DATA) begin
        if (tick) bit_idx_q <= bit_idx_q + 1'b1;
      end else begin
        bit_idx_q <= '0;
      end

      if (state_q == ST_LOAD && is_status) begin
        if (skip_status) begin
          tx_byte_q  <= d0_q;
          nxt_byte_q <= d1_q;
          rem_q      <= n_data - 2'd1;
        end else begin
          tx_byte_q  <= cmd_q;
          nxt_byte_q <= d0_q;
          rem_q      <= n_data;
        end
        if (RS_ENABLE != 0) begin
          if (is_chan)        rs_q <= cmd_q;
          else if (is_common) rs_q <= '0;
        end
      end

      // Only d1 can follow the byte loaded here, whichever byte came first
      if (state_q == ST_NEXT) begin
        tx_byte_q  <= nxt_byte_q;
        nxt_byte_q <= d1_q;
        rem_q      <= rem_q - 2'd1;
      end
    end
  end

  assign MSG_READY = (state_q == ST_IDLE);
  assign TX_BUSY   = (state_q != ST_IDLE);
  assign MIDI_OUT  = line_q;
  assign MSG_ERR   = err_q;

endmodule

// File: tb/tb_midi_message_tx.sv
// tb/tb_midi_message_tx.sv - self-checking bench for midi_message_tx

`timescale 1ns/1ps

module tb_midi_message_tx;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] MIDI_CMD = 8'h00;
  logic [7:0] MIDI_DAT_0 = 8'h00;
  logic [7:0] MIDI_DAT_1 = 8'h00;
  logic       MSG_VALID = 1'b0;
  logic       MSG_READY, MIDI_OUT, TX_BUSY, MSG_ERR;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         st_q[$];
  logic [7:0] m_rs = 8'h00;
  int         frame_err = 0;

  midi_message_tx #(
    .BYTE_W(8), .SYSCLK_F(312500), .MIDI_BAUD(31250), .RS_ENABLE(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .MIDI_CMD(MIDI_CMD), .MIDI_DAT_0(MIDI_DAT_0), .MIDI_DAT_1(MIDI_DAT_1),
    .MSG_VALID(MSG_VALID), .MSG_READY(MSG_READY), .MIDI_OUT(MIDI_OUT),
    .TX_BUSY(TX_BUSY), .MSG_ERR(MSG_ERR)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (MSG_VALID && MSG_READY) acc_cnt <= acc_cnt + 1;
  end

  // Line receiver: 10 cycles per bit, sampled mid-bit on the falling clock edge
  bit         m_act = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_byte = 8'h00;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (MIDI_OUT == 1'b0) begin
        m_act = 1'b1;
        m_cnt = 0;
        st_q.push_back(cyc);
      end
    end else begin
      m_cnt++;
      if (m_cnt % 10 == 5) begin
        if (m_cnt / 10 == 0) begin
          if (MIDI_OUT !== 1'b0) frame_err++;
        end else if (m_cnt / 10 <= 8) begin
          m_byte[m_cnt / 10 - 1] = MIDI_OUT;
        end else begin
          if (MIDI_OUT !== 1'b1) frame_err++;
          rx_q.push_back(m_byte);
        end
      end
      if (m_cnt == 95) m_act = 1'b0;
    end
  end

  // Reference model: bytes expected on the line for one accepted message
  task automatic model_push(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1);
    int n;
    bit send_s;
    if (c < 8'h80) return;
    if ((c >= 8'hC0 && c <= 8'hDF) || c == 8'hF1 || c == 8'hF3) n = 1;
    else if (c >= 8'hF0 && c != 8'hF2) n = 0;
    else n = 2;
    send_s = 1'b1;
    if (c < 8'hF0) begin
      if (c == m_rs) send_s = 1'b0;
      m_rs = c;
    end else if (c < 8'hF8) begin
      m_rs = 8'h00;
    end
    if (send_s) exp_q.push_back(c);
    if (n >= 1) exp_q.push_back(d0);
    if (n == 2) exp_q.push_back(d1);
  endtask

  // Drive one message; returns the cycle count seen on the falling edge after acceptance
  task automatic drive(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1, output int acc);
    int i;
    @(negedge sys_clk);
    MIDI_CMD = c; MIDI_DAT_0 = d0; MIDI_DAT_1 = d1; MSG_VALID = 1'b1;
    for (i = 0; i < 2000 && !MSG_READY; i++) @(negedge sys_clk);
    total++;
    if (!MSG_READY) begin
      bad++;
      $display("FAIL drive_accept: MSG_READY=%b, required 1 within 2000 cycles", MSG_READY);
    end
    @(posedge sys_clk);
    model_push(c, d0, d1);
    @(negedge sys_clk);
    MSG_VALID = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_ready(output int t);
    int i;
    t = -1;
    for (i = 0; i < 2000; i++) begin
      @(negedge sys_clk);
      if (MSG_READY) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge sys_clk);
    total += 4;
    if (MIDI_OUT !== 1'b1) begin bad++; $display("FAIL reset_line: got %b want 1", MIDI_OUT); end
    if (MSG_READY !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", MSG_READY); end
    if (TX_BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", TX_BUSY); end
    if (MSG_ERR !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", MSG_ERR); end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_basic_timing;
    int acc, t;
    logic [7:0] e, r;
    st_q.delete();
    drive(8'h90, 8'h3C, 8'h64, acc);
    total++;
    if (TX_BUSY !== 1'b1 || MSG_READY !== 1'b0) begin
      bad++; $display("FAIL basic_busy: busy=%b ready=%b want 1/0", TX_BUSY, MSG_READY);
    end
    wait_ready(t);
    total++;
    if (t != acc + 303) begin bad++; $display("FAIL basic_ready_latency: got %0d want %0d", t - acc, 303); end
    total++;
    if (TX_BUSY !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", TX_BUSY); end
    total++;
    if (st_q.size() != 3) begin
      bad++; $display("FAIL basic_start_count: got %0d want 3", st_q.size());
    end else begin
      total += 2;
      if (st_q[0] != acc + 2) begin bad++; $display("FAIL basic_start_latency: got %0d want 2", st_q[0] - acc); end
      if (st_q[1] - st_q[0] != 101 || st_q[2] - st_q[1] != 101) begin
        bad++; $display("FAIL basic_byte_spacing: got %0d,%0d want 101,101", st_q[1] - st_q[0], st_q[2] - st_q[1]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rx_q.size() == 0) begin bad++; $display("FAIL basic_frame: missing byte, want %02h", e); end
      else begin r = rx_q.pop_front(); if (r !== e) begin bad++; $display("FAIL basic_frame: got %02h want %02h", r, e); end end
    end
    total++;
    if (rx_q.size() != 0 || frame_err != 0) begin
      bad++; $display("FAIL basic_extra: extra=%0d framing=%0d want 0,0", rx_q.size(), frame_err);
    end
    rx_q.delete();
  endtask

  task automatic test_running_status;
    int acc, t, k;
    logic [7:0] e, r;
    logic [7:0] c_tab[9]  = '{8'h90, 8'h80, 8'hC5, 8'hF8, 8'hC5, 8'hF2, 8'hC5, 8'hF6, 8'hE3};
    logic [7:0] d0_tab[9] = '{8'h40, 8'h40, 8'h07, 8'h00, 8'h08, 8'h10, 8'h09, 8'h55, 8'h11};
    logic [7:0] d1_tab[9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h66, 8'h22};
    for (k = 0; k < 9; k++) begin
      drive(c_tab[k], d0_tab[k], d1_tab[k], acc);
      wait_ready(t);
      total++;
      if (t < 0) begin bad++; $display("FAIL rs_timeout: msg %0d ready=%b want 1", k, MSG_READY); end
      repeat (2) @(negedge sys_clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (rx_q.size() == 0) begin bad++; $display("FAIL rs_frame: msg %0d missing byte, want %02h", k, e); end
        else begin r = rx_q.pop_front(); if (r !== e) begin bad++; $display("FAIL rs_frame: msg %0d got %02h want %02h", k, r, e); end end
      end
      total++;
      if (rx_q.size() != 0) begin bad++; $display("FAIL rs_extra: msg %0d got %0d extra bytes want 0", k, rx_q.size()); end
      rx_q.delete();
    end
  endtask

  task automatic test_invalid;
    int acc, i, errs, rdy_at;
    st_q.delete();
    drive(8'h3C, 8'h11, 8'h22, acc);
    errs = 0; rdy_at = -1;
    for (i = 0; i < 12; i++) begin
      if (MSG_ERR) errs++;
      if (MSG_READY && rdy_at < 0) rdy_at = cyc;
      @(negedge sys_clk);
    end
    total += 3;
    if (errs != 1) begin bad++; $display("FAIL invalid_err_width: got %0d cycles want 1", errs); end
    if (rdy_at < 0 || rdy_at > acc + 2) begin bad++; $display("FAIL invalid_ready: got %0d want <=2", rdy_at - acc); end
    if (st_q.size() != 0 || rx_q.size() != 0) begin
      bad++; $display("FAIL invalid_line: starts=%0d bytes=%0d want 0,0", st_q.size(), rx_q.size());
    end
  endtask

  task automatic test_back_to_back;
    int i, idx, a0;
    logic [7:0] e, r;
    logic [7:0] c_tab[3]  = '{8'hB0, 8'hB1, 8'hB1};
    logic [7:0] d0_tab[3] = '{8'h07, 8'h0A, 8'h0B};
    logic [7:0] d1_tab[3] = '{8'h7F, 8'h40, 8'h41};
    idx = 0;
    a0 = acc_cnt;
    @(negedge sys_clk);
    MSG_VALID = 1'b1;
    for (i = 0; i < 1500; i++) begin
      if (MSG_READY) begin
        if (idx == 3) break;
        MIDI_CMD = c_tab[idx]; MIDI_DAT_0 = d0_tab[idx]; MIDI_DAT_1 = d1_tab[idx];
        model_push(c_tab[idx], d0_tab[idx], d1_tab[idx]);
        idx++;
      end else begin
        MIDI_CMD = 8'($urandom); MIDI_DAT_0 = 8'($urandom); MIDI_DAT_1 = 8'($urandom);
      end
      @(negedge sys_clk);
    end
    MSG_VALID = 1'b0;
    repeat (2) @(negedge sys_clk);
    total += 2;
    if (idx != 3) begin bad++; $display("FAIL b2b_timeout: issued %0d want 3", idx); end
    if (acc_cnt - a0 != 3) begin bad++; $display("FAIL b2b_accepts: got %0d want 3", acc_cnt - a0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rx_q.size() == 0) begin bad++; $display("FAIL b2b_frame: missing byte, want %02h", e); end
      else begin r = rx_q.pop_front(); if (r !== e) begin bad++; $display("FAIL b2b_frame: got %02h want %02h", r, e); end end
    end
    total++;
    if (rx_q.size() != 0) begin bad++; $display("FAIL b2b_extra: got %0d extra bytes want 0", rx_q.size()); end
    rx_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    int acc, t, i;
    logic [7:0] e, r;
    drive(8'h90, 8'h3C, 8'h64, acc);
    for (i = 0; i < 500 && cyc < acc + 143; i++) @(negedge sys_clk);
    total++;
    if (TX_BUSY !== 1'b1) begin bad++; $display("FAIL rst_mid_busy: got %b want 1", TX_BUSY); end
    sys_rst_n = 1'b0;
    #1;
    total += 3;
    if (MIDI_OUT !== 1'b1) begin bad++; $display("FAIL rst_mid_line: got %b want 1", MIDI_OUT); end
    if (MSG_READY !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", MSG_READY); end
    if (TX_BUSY !== 1'b0) begin bad++; $display("FAIL rst_mid_busy_clr: got %b want 0", TX_BUSY); end
    exp_q.delete();
    rx_q.delete();
    m_rs = 8'h00;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    drive(8'h90, 8'h3C, 8'h64, acc);
    wait_ready(t);
    repeat (2) @(negedge sys_clk);
    total++;
    if (exp_q.size() != 3) begin bad++; $display("FAIL rst_mid_model: got %0d expected bytes want 3", exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rx_q.size() == 0) begin bad++; $display("FAIL rst_after_frame: missing byte, want %02h", e); end
      else begin r = rx_q.pop_front(); if (r !== e) begin bad++; $display("FAIL rst_after_frame: got %02h want %02h", r, e); end end
    end
    total++;
    if (rx_q.size() != 0 || frame_err != 0) begin
      bad++; $display("FAIL rst_after_extra: extra=%0d framing=%0d want 0,0", rx_q.size(), frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_running_status();
    test_invalid();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
